fir_decim_requant: RTL and testbench
====================================

// Module: fir_decim_requant
// PURPOSE
// - Output stage placed directly downstream of the symmetric FIR filter. Consumes the full-precision
//   FIR result (data_in/valid_in) and keeps one sample in every DECIM_FACTOR.
// - Rounds and arithmetic-shifts each kept sample, saturates it to OUT_WIDTH, and buffers it in a
//   small FIFO. Results leave on a valid/ready stream, so a back-pressuring consumer does not stall the filter.
// PARAMETERS
// - IN_WIDTH      36  signed input width (FIR output: 16+16+$clog2(5)+1)
// - OUT_WIDTH     16  signed output width
// - FRAC_SHIFT    15  right-shift applied after rounding; range 1..IN_WIDTH-2
// - DECIM_FACTOR  2   keep 1 of every DECIM_FACTOR input samples; 1 = no decimation
// - FIFO_DEPTH    4   output buffer entries; power of two, >=2
// PORTS
// - clk        in   1          clock, all logic on rising edge
// - rst        in   1          synchronous reset, active-high
// - data_in    in   IN_WIDTH   signed FIR result
// - valid_in   in   1          data_in qualifier; no back-pressure to the FIR
// - data_out   out  OUT_WIDTH  signed requantised sample (FIFO head)
// - valid_out  out  1          FIFO non-empty
// - ready_in   in   1          downstream accepts data_out when valid_out & ready_in
// - drop       out  1          1-cycle pulse: a kept sample was lost because the FIFO was full
// - sat_flag   out  1          sticky: a kept sample saturated; cleared only by rst
// - ovf_flag   out  1          sticky: a drop occurred; cleared only by rst
// BEHAVIOUR
// - Reset (rst=1 at posedge):
//   - phase=0, stage-1 valid=0, FIFO empty (pointers 0).
//   - data_out=0, valid_out=0, drop=0, sat_flag=0, ovf_flag=0.
//   - A reset asserted mid-stream discards everything in flight. No output is produced during reset.
// - Decimation:
//   - phase counter 0..DECIM_FACTOR-1 advances only on valid_in and wraps to 0.
//   - A sample is kept when valid_in=1 and phase==0. The first valid after reset is kept.
// - Stage 1 (registered, 1 cycle), computed at IN_WIDTH+1 bits:
//   - r = data_in + 2^(FRAC_SHIFT-1)   (round half toward +inf)
//   - q = r >>> FRAC_SHIFT
//   - If q > 2^(OUT_WIDTH-1)-1, q takes the max value; if q < -2^(OUT_WIDTH-1), q takes the min value.
//     Either clamp sets sat_flag in the same cycle the result is registered.
// - Stage 2 (FIFO):
//   - push = stage-1 valid; pop = valid_out & ready_in.
//   - Full without a same-cycle pop: sample discarded, drop=1 for one cycle, ovf_flag set.
//   - Full with a same-cycle pop: push accepted, occupancy unchanged.
//   - Empty with a push: pop is impossible; the data appears on data_out the next cycle.
//   - Pointers wrap modulo FIFO_DEPTH. Full/empty use an extra pointer MSB.
// - Latency from a kept valid_in to valid_out (FIFO empty) is 2 cycles.
// - data_out holds stable while valid_out=1 & ready_in=0.
// - data_out is the registered FIFO head and is 0 when empty.
// CONFIGURATION
// - FIR_DECIM_CONVERGENT_ROUND_EN defined: round half to even.
//   - If the discarded bits equal exactly 2^(FRAC_SHIFT-1) and the kept LSB is 0, no rounding
//     increment is added. All other cases behave as round-half-up.
// - Undefined: round half toward +inf as above. All other behaviour is identical.
// TESTING (defaults unless stated)
// - Rounding: data_in=16384 (0.5 LSB) -> data_out=1.
//   - With FIR_DECIM_CONVERGENT_ROUND_EN -> data_out=0.
//   - data_in=49152 -> data_out=2 in both builds.
// - Saturation:
//   - data_in=2^31 -> data_out=32767, sat_flag=1.
//   - data_in=-2^31 -> data_out=-32768.
//   - data_in=-32768 -> data_out=-1, sat_flag stays 0 when run from reset.
// - Decimation:
//   - Continuous valid_in with data_in=k*32768, k=0..9 -> outputs 0,2,4,6,8.
//   - First output has valid_out high 2 cycles after the k=0 input.
// - Back-pressure:
//   - ready_in=0 while 6 samples are kept -> 4 buffered, drop pulses on the 5th and 6th, ovf_flag=1.
//   - Then ready_in=1 -> the first 4 values are drained in order, one per cycle.
// - Full with simultaneous pop: FIFO full, ready_in=1 and a kept sample arriving together
//   -> no drop, occupancy stays 4.
// - Mid-stream reset: rst=1 for 1 cycle with 3 entries buffered -> next cycle valid_out=0,
//   data_out=0, flags=0, and the next valid_in is kept (phase=0).

Source files
------------

// File: rtl/fir_decim_requant.sv
// rtl/fir_decim_requant.sv - FIR output decimator: round, shift, saturate, buffer on a valid/ready stream
// Optional build macro: FIR_DECIM_CONVERGENT_ROUND_EN selects round-half-to-even.
module fir_decim_requant #(
   parameter int IN_WIDTH     = 36,
   parameter int OUT_WIDTH    = 16,
   parameter int FRAC_SHIFT   = 15,
   parameter int DECIM_FACTOR = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  data_in,
   input  logic                 valid_in,
   output logic [OUT_WIDTH-1:0] data_out,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic                 drop,
   output logic                 sat_flag,
   output logic                 ovf_flag
);

   localparam int PW = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int W1 = IN_WIDTH + 1;
   localparam logic signed [IN_WIDTH:0] HALF = W1'(1) << (FRAC_SHIFT - 1);
   localparam logic signed [IN_WIDTH:0] QMAX = (W1'(1) << (OUT_WIDTH - 1)) - W1'(1);
   localparam logic signed [IN_WIDTH:0] QMIN = -QMAX - W1'(1);

   logic [PW-1:0]        phase;
   logic                 keep;
   logic signed [IN_WIDTH:0] din_ext;
   logic signed [IN_WIDTH:0] rounded;
   logic signed [IN_WIDTH:0] q;
   logic                 sat_hi;
   logic                 sat_lo;
   logic [OUT_WIDTH-1:0] q_sat;

   logic                 s1_valid;
   logic [OUT_WIDTH-1:0] s1_data;

   logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW:0]          wr_ptr;
   logic [AW:0]          rd_ptr;
   logic [AW:0]          wr_nxt;
   logic [AW:0]          rd_nxt;
   logic                 full;
   logic                 empty;
   logic                 pop;
   logic                 push_ok;
   logic                 drop_nxt;
   logic [OUT_WIDTH-1:0] head_nxt;

   assign keep    = valid_in && (phase == '0);
   assign din_ext = {data_in[IN_WIDTH-1], data_in};

`ifdef FIR_DECIM_CONVERGENT_ROUND_EN
   logic tie_even;
   // exact half with an even kept LSB stays put, giving round-half-to-even
   assign tie_even = (data_in[FRAC_SHIFT-1:0] == HALF[FRAC_SHIFT-1:0]) && !data_in[FRAC_SHIFT];
   assign rounded  = tie_even ? din_ext : din_ext + HALF;
`else
   assign rounded  = din_ext + HALF;
`endif

   assign q      = rounded >>> FRAC_SHIFT;
   assign sat_hi = q > QMAX;
   assign sat_lo = q < QMIN;
   assign q_sat  = sat_hi ? QMAX[OUT_WIDTH-1:0] :
                   sat_lo ? QMIN[OUT_WIDTH-1:0] : q[OUT_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         phase    <= '0;
         s1_valid <= 1'b0;
         s1_data  <= '0;
         sat_flag <= 1'b0;
      end else begin
         if (valid_in) begin
            if (phase == PW'(DECIM_FACTOR - 1)) phase <= '0;
            else                                phase <= phase + PW'(1);
         end
         s1_valid <= keep;
         if (keep) s1_data <= q_sat;
         if (keep && (sat_hi || sat_lo)) sat_flag <= 1'b1;
      end
   end

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign valid_out = !empty;
   assign pop       = !empty && ready_in;
   assign push_ok   = s1_valid && (!full || pop);
   assign drop_nxt  = s1_valid && full && !pop;
   assign wr_nxt    = wr_ptr + {{AW{1'b0}}, push_ok};
   assign rd_nxt    = rd_ptr + {{AW{1'b0}}, pop};

   // data_out is a register, so look ahead to the head the FIFO will have after this edge
   always_comb begin
      head_nxt = '0;
      if (wr_nxt == rd_nxt)      head_nxt = '0;
      else if (wr_ptr == rd_nxt) head_nxt = s1_data;
      else                       head_nxt = mem[rd_nxt[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= s1_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         data_out <= '0;
         drop     <= 1'b0;
         ovf_flag <= 1'b0;
      end else begin
         wr_ptr   <= wr_nxt;
         rd_ptr   <= rd_nxt;
         data_out <= head_nxt;
         drop     <= drop_nxt;
         if (drop_nxt) ovf_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fir_decim_requant.sv
// tb/tb_fir_decim_requant.sv - randomized and directed bench for fir_decim_requant
// Honours FIR_DECIM_CONVERGENT_ROUND_EN in its reference model.
module tb_fir_decim_requant;

   logic        clk = 1'b0;
   logic        rst;
   logic [35:0] data_in;
   logic        valid_in;
   logic [15:0] data_out;
   logic        valid_out;
   logic        ready_in;
   logic        drop;
   logic        sat_flag;
   logic        ovf_flag;

   fir_decim_requant dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .drop      (drop),
      .sat_flag  (sat_flag),
      .ovf_flag  (ovf_flag)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: kept-sample pipeline, bounded output queue, sticky flags
   int     phase_m;
   bit     s1v_m;
   longint s1d_m;
   longint q_m[$];
   bit     drop_m, sat_m, ovf_m;
   longint popped[$];
   int     drops;

   task automatic check(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint requant(input longint x, output bit sat);
      longint fl, rem, r;
      fl  = x >>> 15;
      rem = x - fl * 32768;
      if (rem > 16384) r = fl + 1;
      else if (rem < 16384) r = fl;
`ifdef FIR_DECIM_CONVERGENT_ROUND_EN
      else r = (fl % 2 == 0) ? fl : fl + 1;
`else
      else r = fl + 1;
`endif
      sat = 1'b0;
      if (r > 32767) begin r = 32767; sat = 1'b1; end
      if (r < -32768) begin r = -32768; sat = 1'b1; end
      return r;
   endfunction

   task automatic step(input bit r, input bit v, input longint d, input bit rdy);
      bit     pop, keep, s;
      longint qv;
      rst = r; valid_in = v; data_in = d[35:0]; ready_in = rdy;
      @(negedge clk);
      check("valid_out", valid_out, (q_m.size() > 0) ? 1 : 0);
      check("data_out", $signed(data_out), (q_m.size() > 0) ? q_m[0] : 0);
      check("drop", drop, drop_m);
      check("sat_flag", sat_flag, sat_m);
      check("ovf_flag", ovf_flag, ovf_m);
      if (valid_out && rdy) popped.push_back(longint'($signed(data_out)));
      if (drop) drops++;
      if (r) begin
         phase_m = 0; s1v_m = 0; s1d_m = 0; q_m.delete();
         drop_m = 0; sat_m = 0; ovf_m = 0;
      end else begin
         pop = (q_m.size() > 0) && rdy;
         if (pop) void'(q_m.pop_front());
         drop_m = 0;
         if (s1v_m) begin
            if (q_m.size() < 4) q_m.push_back(s1d_m);
            else begin drop_m = 1; ovf_m = 1; end
         end
         keep = v && (phase_m == 0);
         if (v) phase_m = (phase_m + 1) % 2;
         s1v_m = keep;
         if (keep) begin
            qv = requant(d, s);
            s1d_m = qv;
            if (s) sat_m = 1;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic directed(input string tag, input longint d, input longint exp_q, input bit exp_sat);
      step(1, 0, 0, 1);
      step(0, 1, d, 0);
      step(0, 0, 0, 0);
      check({tag, "_valid_lat2"}, valid_out, 1);
      check({tag, "_value"}, $signed(data_out), exp_q);
      check({tag, "_sat"}, sat_flag, exp_sat);
   endtask

   initial begin
      longint d;
      int     sel;
      rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_in = 1'b0;
      phase_m = 0; s1v_m = 0; s1d_m = 0; drop_m = 0; sat_m = 0; ovf_m = 0; drops = 0;
      repeat (2) @(posedge clk);
      #1;
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);

`ifdef FIR_DECIM_CONVERGENT_ROUND_EN
      directed("round_half", 16384, 0, 0);
`else
      directed("round_half", 16384, 1, 0);
`endif
      directed("round_1p5", 49152, 2, 0);
      directed("neg_small", -32768, -1, 0);
      directed("sat_pos", 64'sd2147483648, 32767, 1);
      directed("sat_neg", -64'sd2147483648, -32768, 1);

      // decimation with continuous valid
      step(1, 0, 0, 1);
      popped.delete();
      for (int k = 0; k < 10; k++) step(0, 1, k * 32768, 1);
      repeat (4) step(0, 0, 0, 1);
      check("decim_count", popped.size(), 5);
      for (int i = 0; i < 5 && i < popped.size(); i++) check("decim_value", popped[i], 2 * i);

      // back-pressure: 6 kept with ready low
      step(1, 0, 0, 0);
      drops = 0;
      for (int i = 0; i < 12; i++) step(0, 1, (i + 1) * 65536, 0);
      repeat (3) step(0, 0, 0, 0);
      check("bp_drops", drops, 2);
      check("bp_ovf", ovf_flag, 1);
      popped.delete();
      repeat (5) step(0, 0, 0, 1);
      check("bp_drain_count", popped.size(), 4);
      for (int i = 0; i < 4 && i < popped.size(); i++) check("bp_drain_value", popped[i], 4 * i + 2);

      // full FIFO with simultaneous pop and push
      step(1, 0, 0, 0);
      drops = 0;
      for (int i = 0; i < 8; i++) step(0, 1, i * 32768, 0);
      repeat (2) step(0, 0, 0, 0);
      step(0, 1, 99 * 32768, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      check("fullpop_drops", drops, 0);
      popped.delete();
      repeat (6) step(0, 0, 0, 1);
      check("fullpop_count", popped.size(), 4);

      // mid-stream reset with 3 entries buffered
      step(1, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 1, (i + 3) * 32768, 0);
      repeat (2) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 1, 7 * 32768, 0);
      check("mrst_valid", valid_out, 0);
      check("mrst_data", $signed(data_out), 0);
      step(0, 0, 0, 0);
      check("mrst_first_kept", $signed(data_out), 7);

      // randomized traffic
      step(1, 0, 0, 1);
      for (int n = 0; n < 800; n++) begin
         sel = $urandom_range(0, 3);
         d = longint'($signed($urandom));
         case (sel)
            0: d = d >>> 8;
            1: d = d <<< 4;
            2: d = (longint'($urandom_range(0, 200)) - 100) * 32768 + 16384;
            default: d = d;
         endcase
         step(0, $urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
      end
      repeat (8) step(0, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
